// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types for the FIFO sharing arbiter.
//   state_t : arbiter FSM states
//   op_t    : kind of the last completed FIFO operation, used to alternate
//             between writers and readers when both classes are eligible
//   other_op: returns the opposite operation kind
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RDATA = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    function automatic op_t other_op(input op_t op);
        return (op == OP_READ) ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker. The winner is the first set request bit
// at or after ptr_i, searching upward with wrap-around.
// Ports:
//   req_i     in  NUM_REQ  request vector
//   ptr_i     in  IDX_W    search start index (always < NUM_REQ)
//   gnt_idx_o out IDX_W    index of the winning request (0 when none)
//   any_o     out 1        at least one request is set
// -----------------------------------------------------------------------------
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_o
);

    localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);

    // One extra bit so ptr+i can be compared against NUM_REQ before wrapping.
    logic [IDX_W:0] sum_s;
    logic [IDX_W:0] cand_s;
    logic           hit_s;

    // Scan candidates in rotated order; the first hit wins.
    always_comb begin
        any_o     = 1'b0;
        gnt_idx_o = {IDX_W{1'b0}};
        sum_s     = {(IDX_W+1){1'b0}};
        cand_s    = {(IDX_W+1){1'b0}};
        hit_s     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s     = {1'b0, ptr_i} + (IDX_W+1)'(i);
            cand_s    = (sum_s >= NUM_W) ? (sum_s - NUM_W) : sum_s;
            hit_s     = !any_o && req_i[cand_s[IDX_W-1:0]];
            gnt_idx_o = hit_s ? cand_s[IDX_W-1:0] : gnt_idx_o;
            any_o     = any_o | hit_s;
        end
    end

endmodule

// File: rtl/fifo_share_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_share_arbiter
// Shares one single-ported FIFO between NUM_REQ writers and NUM_REQ readers.
// One FIFO operation is in flight at a time: IDLE decides, then WRITE (1 cycle)
// or READ + RDATA (2 cycles) or FLUSH (1 cycle). Occupancy is tracked here, the
// FIFO's own EMPTY/FULL flags are not used.
// Ports:
//   Clk, Rst   clock, synchronous active-high reset
//   flush      request to empty the FIFO (beats all requests)
//   wr_req     per-writer request, wr_data slice i = [i*DATA_W +: DATA_W]
//   wr_gnt     one-hot write-accepted pulse
//   rd_req     per-reader request
//   rd_gnt     one-hot pulse, rd_data valid for that reader
//   rd_data    read data, zero when no rd_gnt
//   level      occupancy 0..DEPTH
//   fifo_*     FIFO pins EN, Rst, WR, RD, dataIn, dataOut
// -----------------------------------------------------------------------------
module fifo_share_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 32,
    parameter int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        wr_req,
    input  logic [NUM_REQ*DATA_W-1:0] wr_data,
    output logic [NUM_REQ-1:0]        wr_gnt,
    input  logic [NUM_REQ-1:0]        rd_req,
    output logic [NUM_REQ-1:0]        rd_gnt,
    output logic [DATA_W-1:0]         rd_data,
    output logic [LVL_W-1:0]          level,
    output logic                      fifo_en,
    output logic                      fifo_rst,
    output logic                      fifo_wr,
    output logic                      fifo_rd,
    output logic [DATA_W-1:0]         fifo_din,
    input  logic [DATA_W-1:0]         fifo_dout
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_t              state_q;
    op_t                 last_op_q;
    logic [LVL_W-1:0]    level_q;
    logic [IDX_W-1:0]    wr_ptr_q;
    logic [IDX_W-1:0]    rd_ptr_q;
    logic [IDX_W-1:0]    sel_q;
    logic                flush_pend_q;
    logic [NUM_REQ-1:0]  wr_gnt_q;
    logic [NUM_REQ-1:0]  rd_gnt_q;
    logic                fifo_wr_q;
    logic                fifo_rd_q;
    logic [DATA_W-1:0]   fifo_din_q;

    logic [NUM_REQ-1:0]  ew_s;
    logic [NUM_REQ-1:0]  er_s;
    logic [IDX_W-1:0]    wr_idx_s;
    logic [IDX_W-1:0]    rd_idx_s;
    logic                wr_any_s;
    logic                rd_any_s;
    logic                flush_s;
    logic                pick_write_s;
    logic                pick_read_s;
    logic [DATA_W-1:0]   wr_word_s [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign wr_word_s[g] = wr_data[g*DATA_W +: DATA_W];
    end

    rr_picker #(.NUM_REQ(NUM_REQ)) u_wr_pick (
        .req_i     (ew_s),
        .ptr_i     (wr_ptr_q),
        .gnt_idx_o (wr_idx_s),
        .any_o     (wr_any_s)
    );

    rr_picker #(.NUM_REQ(NUM_REQ)) u_rd_pick (
        .req_i     (er_s),
        .ptr_i     (rd_ptr_q),
        .gnt_idx_o (rd_idx_s),
        .any_o     (rd_any_s)
    );

    // Eligibility masks and the IDLE decision; full FIFO holds writers, empty
    // FIFO holds readers, and a tie goes to the class not served last.
    always_comb begin
        ew_s         = (level_q < DEPTH_L) ? wr_req : {NUM_REQ{1'b0}};
        er_s         = (level_q != {LVL_W{1'b0}}) ? rd_req : {NUM_REQ{1'b0}};
        flush_s      = flush | flush_pend_q;
        pick_write_s = wr_any_s && (!rd_any_s || (other_op(last_op_q) == OP_WRITE));
        pick_read_s  = rd_any_s && !pick_write_s;
    end

    // Arbiter FSM; all FIFO strobes and grants are registered on state entry.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            last_op_q    <= OP_READ;
            level_q      <= {LVL_W{1'b0}};
            wr_ptr_q     <= {IDX_W{1'b0}};
            rd_ptr_q     <= {IDX_W{1'b0}};
            sel_q        <= {IDX_W{1'b0}};
            flush_pend_q <= 1'b0;
            wr_gnt_q     <= {NUM_REQ{1'b0}};
            rd_gnt_q     <= {NUM_REQ{1'b0}};
            fifo_wr_q    <= 1'b0;
            fifo_rd_q    <= 1'b0;
            fifo_din_q   <= {DATA_W{1'b0}};
        end else begin
            wr_gnt_q  <= {NUM_REQ{1'b0}};
            rd_gnt_q  <= {NUM_REQ{1'b0}};
            fifo_wr_q <= 1'b0;
            fifo_rd_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (flush_s) begin
                        state_q      <= ST_FLUSH;
                        flush_pend_q <= 1'b0;
                    end else if (pick_write_s) begin
                        state_q            <= ST_WRITE;
                        sel_q              <= wr_idx_s;
                        wr_ptr_q           <= (wr_idx_s == LAST_IDX) ? {IDX_W{1'b0}} : wr_idx_s + 1'b1;
                        wr_gnt_q[wr_idx_s] <= 1'b1;
                        fifo_wr_q          <= 1'b1;
                        fifo_din_q         <= wr_word_s[wr_idx_s];
                    end else if (pick_read_s) begin
                        state_q   <= ST_READ;
                        sel_q     <= rd_idx_s;
                        rd_ptr_q  <= (rd_idx_s == LAST_IDX) ? {IDX_W{1'b0}} : rd_idx_s + 1'b1;
                        fifo_rd_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    // A flush arriving mid-operation is remembered for the next IDLE.
                    flush_pend_q <= flush_pend_q | flush;
                    level_q      <= (level_q != DEPTH_L) ? level_q + 1'b1 : level_q;
                    last_op_q    <= OP_WRITE;
                    state_q      <= ST_IDLE;
                end
                ST_READ: begin
                    // FIFO presents the word on dataOut during RDATA.
                    flush_pend_q    <= flush_pend_q | flush;
                    rd_gnt_q[sel_q] <= 1'b1;
                    state_q         <= ST_RDATA;
                end
                ST_RDATA: begin
                    flush_pend_q <= flush_pend_q | flush;
                    level_q      <= (level_q != {LVL_W{1'b0}}) ? level_q - 1'b1 : level_q;
                    last_op_q    <= OP_READ;
                    state_q      <= ST_IDLE;
                end
                ST_FLUSH: begin
                    level_q <= {LVL_W{1'b0}};
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_en  = 1'b1;
    assign fifo_rst = Rst | (state_q == ST_FLUSH);
    assign fifo_wr  = fifo_wr_q;
    assign fifo_rd  = fifo_rd_q;
    assign fifo_din = fifo_din_q;
    assign level    = level_q;

    // A reset arriving in the grant cycle suppresses the grant and its data.
    assign wr_gnt  = wr_gnt_q & {NUM_REQ{~Rst}};
    assign rd_gnt  = rd_gnt_q & {NUM_REQ{~Rst}};
    assign rd_data = ((state_q == ST_RDATA) && !Rst) ? fifo_dout : {DATA_W{1'b0}};

endmodule

// File: tb/tb_fifo_share_arbiter.sv
module tb_fifo_share_arbiter;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int LW    = 6;

    logic            Clk   = 1'b0;
    logic            Rst   = 1'b1;
    logic            flush = 1'b0;
    logic [N-1:0]    wr_req  = '0;
    logic [N*DW-1:0] wr_data = '0;
    logic [N-1:0]    rd_req  = '0;
    logic [N-1:0]    wr_gnt;
    logic [N-1:0]    rd_gnt;
    logic [DW-1:0]   rd_data;
    logic [LW-1:0]   level;
    logic            fifo_en;
    logic            fifo_rst;
    logic            fifo_wr;
    logic            fifo_rd;
    logic [DW-1:0]   fifo_din;
    logic [DW-1:0]   fifo_dout = '0;

    always #5 Clk = ~Clk;

    fifo_share_arbiter #(.NUM_REQ(N), .DATA_W(DW), .DEPTH(DEPTH), .LVL_W(LW)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .flush     (flush),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .rd_req    (rd_req),
        .rd_gnt    (rd_gnt),
        .rd_data   (rd_data),
        .level     (level),
        .fifo_en   (fifo_en),
        .fifo_rst  (fifo_rst),
        .fifo_wr   (fifo_wr),
        .fifo_rd   (fifo_rd),
        .fifo_din  (fifo_din),
        .fifo_dout (fifo_dout)
    );

    typedef struct packed {
        logic          is_rd;
        logic [1:0]    idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   auto_drop = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural FIFO: dataOut is registered on the edge that samples RD.
    logic [DW-1:0] fmem [DEPTH];
    int fhead = 0;
    int ftail = 0;
    always @(posedge Clk) begin
        if (fifo_rst) begin
            fhead <= 0;
            ftail <= 0;
        end else begin
            if (fifo_wr) begin
                fmem[ftail] <= fifo_din;
                ftail       <= (ftail + 1) % DEPTH;
            end
            if (fifo_rd) begin
                fifo_dout <= fmem[fhead];
                fhead     <= (fhead + 1) % DEPTH;
            end
        end
    end

    // Scoreboard monitor: every grant must match the next expected transaction.
    always @(negedge Clk) begin
        chk("wr_rd_exclusive", fifo_wr & fifo_rd, 0);
        if (wr_gnt != '0 || rd_gnt != '0) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_gnt", {wr_gnt, rd_gnt}, 0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.is_rd) begin
                    chk("rd_gnt", rd_gnt, 4'b0001 << mon_e.idx);
                    chk("wr_gnt_during_rd", wr_gnt, 0);
                    chk("rd_data", rd_data, mon_e.data);
                end else begin
                    chk("wr_gnt", wr_gnt, 4'b0001 << mon_e.idx);
                    chk("rd_gnt_during_wr", rd_gnt, 0);
                    chk("fifo_wr", fifo_wr, 1);
                    chk("fifo_din", fifo_din, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
        if (auto_drop) begin
            wr_req = wr_req & ~wr_gnt;
            rd_req = rd_req & ~rd_gnt;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic push_exp(input logic is_rd, input int idx, input logic [DW-1:0] d);
        exp_t e;
        e.is_rd = is_rd;
        e.idx   = 2'(idx);
        e.data  = d;
        sb_q.push_back(e);
    endtask

    task automatic write_one(input int p, input logic [DW-1:0] d);
        wr_data[p*DW +: DW] = d;
        wr_req[p] = 1'b1;
        push_exp(1'b0, p, d);
        run(2);
    endtask

    task automatic flush_idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_rst_pulse", fifo_rst, 1);
        tick();
        chk("flush_level", level, 0);
        chk("flush_rst_done", fifo_rst, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        run(2);
        chk("rst_level", level, 0);
        chk("rst_wr_gnt", wr_gnt, 0);
        chk("rst_rd_gnt", rd_gnt, 0);
        chk("rst_fifo_wr", fifo_wr, 0);
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_fifo_din", fifo_din, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_fifo_en", fifo_en, 1);
        chk("rst_fifo_rst", fifo_rst, 1);

        // Four writers at once: round-robin order 0..3, one grant every 2 cycles
        Rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            wr_data[i*DW +: DW] = 32'h10 + 32'(i);
            push_exp(1'b0, i, 32'h10 + 32'(i));
        end
        wr_req = 4'b1111;
        #1;
        chk("fifo_rst_released", fifo_rst, 0);
        for (int k = 0; k < N; k++) begin
            tick();
            chk("rr_wr_order", wr_gnt, 4'b0001 << k);
            tick();
            chk("rr_wr_level", level, k + 1);
            chk("rr_wr_gap", wr_gnt, 0);
        end

        // Two reads bring level to 2 with last_op=READ
        rd_req = 4'b0001;
        push_exp(1'b1, 0, 32'h10);
        run(3);
        rd_req = 4'b0001;
        push_exp(1'b1, 0, 32'h11);
        run(3);
        chk("pre_alt_level", level, 2);

        // Held writer 1 and reader 2: write, read, write, read ...
        auto_drop = 1'b0;
        wr_data[1*DW +: DW] = 32'h20;
        wr_req = 4'b0010;
        rd_req = 4'b0100;
        push_exp(1'b0, 1, 32'h20);
        push_exp(1'b1, 2, 32'h12);
        push_exp(1'b0, 1, 32'h20);
        push_exp(1'b1, 2, 32'h13);
        push_exp(1'b0, 1, 32'h20);
        push_exp(1'b1, 2, 32'h20);
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("alt_level_range", (level >= 2) && (level <= 3), 1);
        end
        wr_req = '0;
        rd_req = '0;
        auto_drop = 1'b1;
        tick();
        chk("alt_level_end", level, 2);

        // Flush from IDLE, then fill to DEPTH
        flush_idle();
        for (int k = 0; k < DEPTH; k++) begin
            write_one(0, 32'h100 + 32'(k));
        end
        chk("full_level", level, DEPTH);
        wr_data[0 +: DW] = 32'h999;
        wr_req = 4'b0001;
        rd_req = 4'b1000;
        push_exp(1'b1, 3, 32'h100);
        push_exp(1'b0, 0, 32'h999);
        tick();
        chk("full_no_write", fifo_wr, 0);
        chk("full_read_first", fifo_rd, 1);
        run(4);
        chk("full_refill_level", level, DEPTH);

        // Empty FIFO: readers held until a word arrives
        flush_idle();
        rd_req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("empty_no_rd", fifo_rd, 0);
        end
        wr_data[1*DW +: DW] = 32'hA5;
        wr_req = 4'b0010;
        push_exp(1'b0, 1, 32'hA5);
        push_exp(1'b1, 0, 32'hA5);
        run(2);
        chk("empty_wr_level", level, 1);
        tick();
        chk("empty_read_entered", fifo_rd, 1);
        tick();
        chk("empty_rd_gnt", rd_gnt, 4'b0001);
        chk("empty_rd_data", rd_data, 32'hA5);
        tick();
        chk("empty_after_level", level, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("empty_held_again", fifo_rd, 0);
        end
        rd_req = '0;

        // Flush raised during READ: read completes, then flush
        for (int k = 0; k < 5; k++) begin
            write_one(2, 32'h50 + 32'(k));
        end
        chk("fl_level5", level, 5);
        rd_req = 4'b0010;
        push_exp(1'b1, 1, 32'h50);
        tick();
        chk("fl_in_read", fifo_rd, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_rdata_gnt", rd_gnt, 4'b0010);
        tick();
        chk("fl_level4", level, 4);
        chk("fl_not_yet", fifo_rst, 0);
        tick();
        chk("fl_pulse", fifo_rst, 1);
        tick();
        chk("fl_level0", level, 0);
        chk("fl_pulse_end", fifo_rst, 0);
        rd_req = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fl_reads_blocked", fifo_rd, 0);
        end
        rd_req = '0;

        // Reset in the RDATA cycle: no grant, level cleared
        for (int k = 0; k < 3; k++) begin
            write_one(3, 32'h70 + 32'(k));
        end
        chk("rst_mid_level3", level, 3);
        rd_req = 4'b0001;
        tick();
        tick();
        Rst = 1'b1;
        #1;
        chk("rst_mid_fifo_rst", fifo_rst, 1);
        chk("rst_mid_no_gnt", rd_gnt, 0);
        chk("rst_mid_no_data", rd_data, 0);
        tick();
        chk("rst_mid_level", level, 0);
        chk("rst_mid_gnt_after", rd_gnt, 0);
        chk("rst_mid_fifo_rd", fifo_rd, 0);
        Rst = 1'b0;
        rd_req = '0;
        write_one(0, 32'h33);
        rd_req = 4'b0010;
        push_exp(1'b1, 1, 32'h33);
        run(3);
        chk("post_rst_level", level, 0);

        run(2);
        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_share_arbiter.md
Name: fifo_share_arbiter

Overview:
- Shares one FIFObuffer instance between NUM_REQ producers and NUM_REQ consumers.
- The FIFO performs one operation per clock, so this block serialises accesses through a small FSM and round-robin pickers.
- Keeps its own occupancy count and does not rely on the FIFO's EMPTY/FULL flags. It also drives the FIFO's EN, RD, WR, Rst and dataIn pins.
- Sits between the requester fabric and the FIFO.

Parameters:
- NUM_REQ, 4, number of writer ports and number of reader ports (2..8).
- DATA_W, 32, data width; must equal the FIFO's data_size.
- DEPTH, 32, FIFO capacity; must equal the FIFO's data_alloc.
- LVL_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset, synchronous, active-high.
- flush  in  1  request to empty the FIFO.
- wr_req  in  NUM_REQ  per-writer request; held until the matching wr_gnt bit is seen.
- wr_data  in  NUM_REQ*DATA_W  per-writer data, slice i = [i*DATA_W +: DATA_W]; held with wr_req.
- wr_gnt  out  NUM_REQ  one-hot, one-cycle pulse: write accepted.
- rd_req  in  NUM_REQ  per-reader request; held until the matching rd_gnt bit is seen.
- rd_gnt  out  NUM_REQ  one-hot, one-cycle pulse: rd_data is valid for this reader.
- rd_data  out  DATA_W  read data, valid only while rd_gnt is non-zero.
- level  out  LVL_W  current occupancy, 0..DEPTH.
- fifo_en  out  1  FIFO EN pin.
- fifo_rst  out  1  FIFO Rst pin.
- fifo_wr  out  1  FIFO WR pin.
- fifo_rd  out  1  FIFO RD pin.
- fifo_din  out  DATA_W  FIFO dataIn pin.
- fifo_dout  in  DATA_W  FIFO dataOut pin.

Behaviour:
- Reset:
  - state=IDLE; level=0; wr_ptr=rd_ptr=0; last_op=READ.
  - wr_gnt, rd_gnt, fifo_wr, fifo_rd = 0.
  - fifo_din, rd_data = 0.
  - Rst can interrupt any state, including mid-read; the pending read data is discarded and no gnt is issued.
- FIFO enable and reset:
  - fifo_en is a constant 1, so the FIFO honours its own reset.
  - fifo_rst = Rst OR (state==FLUSH), driven combinationally.
- States: IDLE, WRITE, READ, RDATA, FLUSH. All FIFO controls and grants are registered outputs decoded from state.
- IDLE eligibility:
  - ew = wr_req when level<DEPTH, else 0.
  - er = rd_req when level>0, else 0.
- IDLE decision, in priority order:
  1. flush=1 -> FLUSH. Flush beats every request.
  2. Only ew non-zero -> WRITE.
  3. Only er non-zero -> READ.
  4. Both non-zero -> take the opposite of last_op.
  5. Neither -> stay in IDLE.
- Round-robin pick (rr_picker):
  - Winner = first set bit at or after ptr, searching with wrap-around.
  - On a grant, the class pointer becomes winner+1 mod NUM_REQ.
  - The winner index is latched in sel.
- WRITE (1 cycle):
  - fifo_wr=1, fifo_din=wr_data[sel], wr_gnt[sel]=1.
  - Exit: level+1, last_op=WRITE, -> IDLE.
- READ (1 cycle):
  - fifo_rd=1. The FIFO captures dataOut at the end of this cycle.
  - -> RDATA.
- RDATA (1 cycle):
  - rd_data=fifo_dout, rd_gnt[sel]=1.
  - Exit: level-1, last_op=READ, -> IDLE.
- FLUSH (1 cycle):
  - fifo_rst=1 (FIFO pointers clear), level=0, pointers unchanged.
  - -> IDLE.
- Throughput: a write takes 2 cycles (decide + WRITE); a read takes 3 cycles (decide + READ + RDATA).
- Requester timing: a requester drops its req on the edge that ends its gnt, so the next IDLE sees the updated request vector.
- Boundaries:
  - level==DEPTH: writers are held with no gnt.
  - level==0: readers are held.
  - fifo_wr and fifo_rd are never high in the same cycle.
  - flush raised during WRITE/READ/RDATA: the operation in progress completes; flush is taken in the next IDLE.
  - level never wraps.

Decomposition:
- fifo_arb_pkg:
  - state_t enum (IDLE, WRITE, READ, RDATA, FLUSH).
  - op_t enum (READ, WRITE).
- Sub-module rr_picker:
  - Combinational; ports req[NUM_REQ] and ptr -> gnt_idx, any.
  - Instantiated twice: once for writers, once for readers.

Test Plan:
- Rst mid-RDATA with level=3 -> next cycle state IDLE, level=0, no rd_gnt, fifo_rst=1 during Rst.
- wr_req=4'b1111, data i=0x10+i, no readers -> wr_gnt order 0,1,2,3 on cycles 2,4,6,8; level 1..4.
- level=2, wr_req[1] and rd_req[2] held continuously, last_op=READ -> grants alternate write, read, write...; level steady within 2..3.
- Fill to level=DEPTH(32), wr_req[0]=1 -> no wr_gnt; rd_req[3]=1 -> rd_gnt[3] with first-written word; wr_gnt[0] follows in the next decision.
- level=0, rd_req=4'b0101 -> no rd_gnt, fifo_rd stays 0; write 0xA5 via port 1 -> rd_gnt[0] with rd_data=0xA5, two cycles after READ is entered.
- flush asserted during READ, level=5 -> RDATA completes (level=4), then FLUSH: fifo_rst pulses 1 cycle, level=0, subsequent reads blocked.
